// File: rtl/alu_exec_controller.sv
// Three-cycle execute sequencer around a combinational ALU: IDLE accepts, EXEC captures the ALU, WB commits.
// One command per three cycles; in_ready is high only in IDLE, so upstream stalls through EXEC and WB.
module alu_exec_controller #(
  parameter int N = 4,
  parameter int REGS = 4,
  localparam int AW = $clog2(REGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic          in_setflags,
  input  logic [1:0]    in_cond,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [N-1:0]  load_data,
  output logic [N-1:0]  alu_a,
  output logic [N-1:0]  alu_b,
  output logic [3:0]    alu_control,
  input  logic [N-1:0]  alu_result,
  input  logic          alu_negative,
  input  logic          alu_zero,
  input  logic          alu_carry,
  input  logic          alu_overflow,
  output logic [3:0]    flags,
  output logic          done,
  output logic          skipped,
  input  logic [AW-1:0] rd_addr,
  output logic [N-1:0]  rd_data
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  regs [REGS];
  logic [N-1:0]  a_q, b_q, res_q;
  logic [3:0]    op_q, fl_q;
  logic [AW-1:0] rd_q;
  logic          sf_q;
  logic [1:0]    cond_q;
  logic          accept, pass;

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_control = op_q;
  assign rd_data     = regs[rd_addr];

  // Condition is judged on the committed flags (previous instruction), not on fl_q.
  always_comb begin
    pass = 1'b1;
    case (cond_q)
      2'b00: pass = 1'b1;
      2'b01: pass = flags[2];
      2'b10: pass = !flags[2];
      2'b11: pass = flags[1];
      default: pass = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    done      = 1'b0;
    skipped   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = WB;
      WB: begin
        state_nxt = IDLE;
        done      = !reset;
        skipped   = !reset && !pass;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs   <= '{default: '0};
      flags  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      res_q  <= '0;
      fl_q   <= '0;
      rd_q   <= '0;
      sf_q   <= 1'b0;
      cond_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Operands read the pre-edge file, so a same-cycle load is not forwarded.
          if (load_en) regs[load_addr] <= load_data;
          if (accept) begin
            a_q    <= regs[in_rs1];
            b_q    <= regs[in_rs2];
            op_q   <= in_op;
            rd_q   <= in_rd;
            sf_q   <= in_setflags;
            cond_q <= in_cond;
          end
        end
        EXEC: begin
          res_q <= alu_result;
          fl_q  <= {alu_negative, alu_zero, alu_carry, alu_overflow};
        end
        WB: begin
          if (pass) begin
            regs[rd_q] <= res_q;
            if (sf_q) flags <= fl_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
